icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//  Instruction-fetch responder for the PC stage. Accepts per-cycle fetch requests
//  (address, valid, write-enable) and returns the 32-bit instruction one cycle later.
//  Implemented as a direct-mapped, read-only I-cache that refills 16-byte lines over a
//  64-bit memory read port. Raises stall_o on a miss so the pipeline controller can
//  enter the Stalled state.
// PARAMETERS
//  LINES      64   number of cache lines (power of 2); index width IDX = log2(LINES)
//  ADDR_W     64   fetch/memory address width
//  BEATS      2    64-bit memory beats per line (line = 16 B; offset bits = 4)
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous reset, active-high
//  req_valid_i      in   1       fetch request valid
//  req_addr_i       in   ADDR_W  fetch address (word aligned)
//  req_wen_i        in   1       write enable; writes unsupported, must be 0
//  flush_i          in   1       invalidate all lines (fence.i)
//  resp_valid_o     out  1       instruction valid
//  resp_addr_o      out  ADDR_W  address of returned instruction
//  resp_inst_o      out  32      instruction
//  stall_o          out  1       miss in progress; initiator holds request
//  mem_req_valid_o  out  1       line read request
//  mem_req_addr_o   out  ADDR_W  line-aligned address (addr[3:0]=0)
//  mem_req_ready_i  in   1       memory accepts request
//  mem_resp_valid_i in   1       read beat valid
//  mem_resp_data_i  in   64      read beat, beat 0 = lower address
//  hit_cnt_o        out  32      hit count (feature macro)
//  miss_cnt_o       out  32      miss count (feature macro)
// BEHAVIOUR
//  - Reset: all valid bits 0, FSM=IDLE; resp_valid_o=0, resp_addr_o=0, resp_inst_o=0,
//    stall_o=0, mem_req_valid_o=0, mem_req_addr_o=0, counters=0.
//  - Address split: offset=addr[3:0], index=addr[4+IDX-1:4], tag=addr[ADDR_W-1:4+IDX].
//    Word select: beat=addr[3], half=addr[2] (0 = bits 31:0).
//  - Request accepted when req_valid_i & ~req_wen_i & FSM==IDLE. req_wen_i=1: ignored,
//    no response, no state change.
//  - Hit: resp_valid_o=1 with addr/inst on the next cycle (latency 1); stall_o stays 0.
//  - Miss: stall_o rises combinationally in the request cycle; resp_valid_o=0.
//    FSM: IDLE -miss-> REQ (mem_req_valid_o=1, held until mem_req_ready_i) -> WAIT
//    (capture BEATS beats, beat count 0..BEATS-1) -> FILL (write data, tag, valid=1)
//    -> IDLE, with resp_valid_o=1 for the missed address in the cycle after FILL.
//    stall_o is 1 from the miss cycle through FILL inclusive; 0 when resp is valid.
//  - Initiator holds req_addr_i stable while stall_o=1; the block latches the miss address
//    in the miss cycle and uses only the latch during refill.
//  - mem_resp_valid_i outside WAIT: ignored.
//  - flush_i in IDLE: all valid bits cleared next cycle; a same-cycle request is treated
//    as a miss. flush_i during REQ/WAIT/FILL: latched; refill completes, response is
//    delivered, then all valid bits (including the new line) are cleared.
//  - rst mid-refill: FSM→IDLE, request dropped, beats in flight ignored.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: hit_cnt_o/miss_cnt_o increment once per accepted hit/miss,
//  saturating at 32'hFFFF_FFFF. Undefined: both outputs tied to 0, no counter flops.
// TESTING
//  1. Cold fetch 0x8000_0000, mem beats 0x0000_0093_0000_0013,0 -> stall_o 1 until FILL;
//     resp_inst_o=0x0000_0013, resp_addr_o=0x8000_0000; miss_cnt_o=1.
//  2. Then fetch 0x8000_0004, 0x8000_0008 back-to-back -> hits, resp 1 cycle later,
//     inst 0x0000_0093 then beat1[31:0]; stall_o stays 0; hit_cnt_o=2.
//  3. Fetch 0x8000_0400 (same index, LINES=64, different tag) -> miss, line replaced;
//     refetch 0x8000_0000 -> miss again.
//  4. mem_req_ready_i held 0 for 5 cycles -> mem_req_valid_o/addr stable, stall_o 1 throughout.
//  5. flush_i pulsed during WAIT -> response still delivered; next fetch of same address misses.
//  6. rst asserted in WAIT -> next cycle all outputs at reset values; 0x8000_0000 misses.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache answering PC-stage fetches with 1-cycle hit latency.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_responder #(
    parameter int LINES  = 64,
    parameter int ADDR_W = 64,
    parameter int BEATS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_wen_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    output logic [ADDR_W-1:0] resp_addr_o,
    output logic [31:0]       resp_inst_o,
    output logic              stall_o,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    input  logic [63:0]       mem_resp_data_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int IDX    = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - 4 - IDX;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W = BEATS * 64;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;
    state_t state, state_nxt;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [ADDR_W-1:0] miss_addr;
    logic [LINE_W-1:0] fill_line;
    logic [BW-1:0]     beat_cnt;
    logic              flush_pend;

    logic [IDX-1:0]    req_idx, miss_idx;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word, fill_word;
    logic              accept, hit, miss, last_beat;
    logic              unused_bits;

    assign req_idx   = req_addr_i[4 +: IDX];
    assign req_tag   = req_addr_i[ADDR_W-1 -: TAG_W];
    assign miss_idx  = miss_addr[4 +: IDX];
    assign miss_tag  = miss_addr[ADDR_W-1 -: TAG_W];
    assign hit_line  = data_q[req_idx];
    assign hit_word  = hit_line[{req_addr_i[3:2], 5'd0} +: 32];
    assign fill_word = fill_line[{miss_addr[3:2], 5'd0} +: 32];
    assign last_beat = (beat_cnt == BW'(BEATS - 1));

    // A flush in the same cycle as a request forces a miss so stale lines are never returned.
    assign accept = req_valid_i & ~req_wen_i & (state == S_IDLE);
    assign hit    = accept & ~flush_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign miss   = accept & ~hit;

    assign mem_req_addr_o = (state == S_REQ) ? {miss_addr[ADDR_W-1:4], 4'b0000} : '0;
    assign unused_bits    = ^req_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        stall_o         = 1'b0;
        mem_req_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (miss) begin
                    stall_o   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                stall_o         = 1'b1;
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (mem_resp_valid_i && last_beat) state_nxt = S_FILL;
            end
            S_FILL: begin
                stall_o   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            miss_addr    <= '0;
            fill_line    <= '0;
            beat_cnt     <= '0;
            flush_pend   <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_addr_o  <= '0;
            resp_inst_o  <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            if (hit) begin
                resp_valid_o <= 1'b1;
                resp_addr_o  <= req_addr_i;
                resp_inst_o  <= hit_word;
            end
            if (miss) begin
                miss_addr <= req_addr_i;
                beat_cnt  <= '0;
            end
            if (state == S_WAIT && mem_resp_valid_i) begin
                fill_line[{beat_cnt, 6'd0} +: 64] <= mem_resp_data_i;
                beat_cnt                          <= beat_cnt + BW'(1);
            end
            if (state == S_IDLE) begin
                if (flush_i) valid_q <= '0;
            end else if (state == S_FILL) begin
                resp_valid_o <= 1'b1;
                resp_addr_o  <= miss_addr;
                resp_inst_o  <= fill_word;
                // A flush seen during refill wipes everything, the fresh line included.
                if (flush_pend || flush_i) valid_q <= '0;
                else                       valid_q[miss_idx] <= 1'b1;
                flush_pend <= 1'b0;
            end else if (flush_i) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == S_FILL) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= fill_line;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && hit_cnt != 32'hFFFF_FFFF)   hit_cnt  <= hit_cnt + 32'd1;
            if (miss && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: fetches push expected responses, a monitor pops and compares.
module tb_icache_responder;
    localparam int BEATS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wen, flush;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [63:0] resp_addr;
    logic [31:0] resp_inst;
    logic        stall;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    icache_responder dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wen_i(req_wen), .flush_i(flush),
        .resp_valid_o(resp_valid), .resp_addr_o(resp_addr), .resp_inst_o(resp_inst),
        .stall_o(stall),
        .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr), .mem_req_ready_i(mem_ready),
        .mem_resp_valid_i(mem_rvalid), .mem_resp_data_i(mem_rdata),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_beat(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0093_0000_0013;
        if (a == 64'h8000_0008) return 64'h0;
        return {a[31:0] ^ 32'h1357_9BDF, a[31:0] + 32'h0000_1111};
    endfunction

    function automatic logic [31:0] model_inst(input logic [63:0] a);
        logic [63:0] b;
        b = model_beat({a[63:3], 3'b000});
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_CNT_EN
        check_eq({tag, "_hit_cnt"}, {32'b0, hit_cnt}, 64'(exp_hits));
        check_eq({tag, "_miss_cnt"}, {32'b0, miss_cnt}, 64'(exp_misses));
`else
        check_eq({tag, "_hit_cnt"}, {32'b0, hit_cnt}, 64'd0);
        check_eq({tag, "_miss_cnt"}, {32'b0, miss_cnt}, 64'd0);
`endif
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic fetch(input logic [63:0] a, input bit exp_miss, input int rdy_delay,
                         input bit flush_wait, input bit flush_req);
        logic [63:0] line;
        line      = {a[63:4], 4'b0000};
        req_valid = 1'b1;
        req_addr  = a;
        req_wen   = 1'b0;
        flush     = flush_req;
        if (!exp_miss) sb.push_back('{a, model_inst(a), cyc + 1});
        @(negedge clk);
        check_eq("stall_req", {63'b0, stall}, {63'b0, exp_miss});
        @(posedge clk); #1;
        flush = 1'b0;
        if (!exp_miss) begin
            req_valid = 1'b0;
            exp_hits++;
            return;
        end
        exp_misses++;
        repeat (rdy_delay) begin
            @(negedge clk);
            check_eq("hold_req_valid", {63'b0, mem_req_valid}, 64'd1);
            check_eq("hold_req_addr", mem_req_addr, line);
            check_eq("hold_stall", {63'b0, stall}, 64'd1);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check_eq("mem_req_valid", {63'b0, mem_req_valid}, 64'd1);
        check_eq("mem_req_addr", mem_req_addr, line);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = model_beat(line + 64'(8 * b));
            flush      = flush_wait && (b == 0);
            @(negedge clk);
            check_eq("stall_wait", {63'b0, stall}, 64'd1);
            @(posedge clk); #1;
            flush = 1'b0;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        check_eq("stall_fill", {63'b0, stall}, 64'd1);
        check_eq("fill_no_mem_req", {63'b0, mem_req_valid}, 64'd0);
        sb.push_back('{a, model_inst(a), cyc + 1});
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("stall_resp", {63'b0, stall}, 64'd0);
        check_eq("resp_valid_refill", {63'b0, resp_valid}, 64'd1);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check_eq("resp_unexpected", {63'b0, resp_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("resp_addr", resp_addr, mon_e.addr);
                check_eq("resp_inst", {32'b0, resp_inst}, {32'b0, mon_e.inst});
                check_eq("resp_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resp_valid"}, {63'b0, resp_valid}, 64'd0);
        check_eq({tag, "_resp_addr"}, resp_addr, 64'd0);
        check_eq({tag, "_resp_inst"}, {32'b0, resp_inst}, 64'd0);
        check_eq({tag, "_stall"}, {63'b0, stall}, 64'd0);
        check_eq({tag, "_mem_req_valid"}, {63'b0, mem_req_valid}, 64'd0);
        check_eq({tag, "_mem_req_addr"}, mem_req_addr, 64'd0);
        check_counters(tag);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        flush      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // cold miss, then back-to-back hits in the same line
        fetch(64'h8000_0000, 1'b1, 0, 1'b0, 1'b0);
        check_counters("cold");
        fetch(64'h8000_0004, 1'b0, 0, 1'b0, 1'b0);
        fetch(64'h8000_0008, 1'b0, 0, 1'b0, 1'b0);
        check_counters("hits");

        // write requests are ignored entirely
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 64'h8000_0000;
        @(negedge clk);
        check_eq("wen_stall", {63'b0, stall}, 64'd0);
        check_eq("wen_mem_req", {63'b0, mem_req_valid}, 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        @(negedge clk);
        check_eq("wen_no_resp", {63'b0, resp_valid}, 64'd0);
        @(posedge clk); #1;

        // conflicting tag on index 0 with a slow memory, then eviction check
        fetch(64'h8000_0400, 1'b1, 5, 1'b0, 1'b0);
        fetch(64'h8000_040C, 1'b0, 0, 1'b0, 1'b0);
        fetch(64'h8000_0000, 1'b1, 0, 1'b0, 1'b0);

        // flush during refill: response delivered, then everything invalid
        fetch(64'h8000_0010, 1'b1, 0, 1'b1, 1'b0);
        fetch(64'h8000_0014, 1'b1, 0, 1'b0, 1'b0);
        fetch(64'h8000_0000, 1'b1, 0, 1'b0, 1'b0);
        fetch(64'h8000_0018, 1'b0, 0, 1'b0, 1'b0);
        // flush coincident with a request that would otherwise hit
        fetch(64'h8000_0004, 1'b1, 0, 1'b0, 1'b1);
        fetch(64'h8000_001C, 1'b1, 0, 1'b0, 1'b0);
        check_counters("mid");

        // reset in WAIT with a beat in flight
        req_valid = 1'b1;
        req_addr  = 64'h8000_0020;
        @(negedge clk);
        check_eq("rst_seq_stall", {63'b0, stall}, 64'd1);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = model_beat(64'h8000_0020);
        rst        = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        mem_rdata = model_beat(64'h8000_0028);
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(posedge clk); #1;

        fetch(64'h8000_0000, 1'b1, 0, 1'b0, 1'b0);
        fetch(64'h8000_0020, 1'b1, 0, 1'b0, 1'b0);
        fetch(64'h8000_0024, 1'b0, 0, 1'b0, 1'b0);
        fetch(64'h8000_0008, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        check_counters("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
